sitcp_tx_scheduler: RTL and testbench

Packet-granular round-robin scheduler that shares the SiTCP TCP transmit FIFO port (TX_WR/TX_DATA) among NUM_SRC first-word-fall-through byte sources.
- Gates transfers on connection state (MAIN_OPEN_ACK) and the almost-full flag (TX_FULL).
- Flushes partial packets when the connection drops.
- Sequences the CLOSE_REQ/CLOSE_ACK handshake so a close never truncates a packet.
- Sits between user data producers and the SiTCP core's user interface.

---
 rtl/sitcp_tx_scheduler.sv | 169 ++++++++++++++++
 tb/tb_sitcp_tx_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sitcp_tx_scheduler.sv
// Packet-granular round-robin scheduler sharing the SiTCP TX FIFO port among
// NUM_SRC first-word-fall-through byte sources, with disconnect flush and close sequencing.
module sitcp_tx_scheduler #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   SITCP_RST,
    input  logic                   MAIN_OPEN_ACK,
    input  logic                   TX_FULL,
    input  logic                   CLOSE_REQ,
    output logic                   CLOSE_ACK,
    output logic                   TX_WR,
    output logic [7:0]             TX_DATA,
    input  logic [NUM_SRC-1:0]     SRC_VALID,
    input  logic [8*NUM_SRC-1:0]   SRC_DATA,
    input  logic [NUM_SRC-1:0]     SRC_LAST,
    output logic [NUM_SRC-1:0]     SRC_RD,
    output logic [NUM_SRC-1:0]     GRANT,
    output logic                   BUSY,
    output logic [15:0]            PKT_CNT,
    output logic [7:0]             DROP_CNT
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_FLUSH, S_CLOSE} state_t;

    state_t               state, state_nx;
    logic [PTR_W-1:0]     ptr, ptr_nx;
    logic [NUM_SRC-1:0]   grant_nx;
    logic                 tx_wr_nx;
    logic [7:0]           tx_data_nx;
    logic                 close_ack_nx;
    logic [15:0]          pkt_nx;
    logic [7:0]           drop_nx;

    logic                 own_valid, own_last;
    logic [7:0]           own_data;
    logic                 xfer_go, pop, pkt_end;
    logic [PTR_W-1:0]     win;
    logic                 win_vld;

    // ptr always names the owner while a packet is in flight
    assign own_valid = SRC_VALID[ptr];
    assign own_last  = SRC_LAST[ptr];
    assign own_data  = SRC_DATA[{ptr, 3'b000} +: 8];

    assign xfer_go = (state == S_XFER) && MAIN_OPEN_ACK && !TX_FULL && own_valid;
    assign pop     = !SITCP_RST && (xfer_go || ((state == S_FLUSH) && own_valid));
    assign pkt_end = pop && own_last;

    assign SRC_RD = pop ? (NUM_SRC'(1) << ptr) : '0;
    assign BUSY   = (state != S_IDLE);

    // Round-robin search ptr+1, ptr+2, ...; iterating farthest-first leaves the nearest winner
    always_comb begin
        logic [PTR_W-1:0] idx;
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int unsigned k = NUM_SRC; k >= 1; k--) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_SRC);
            if (SRC_VALID[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)          state <= S_IDLE;
        else if (SITCP_RST) state <= S_IDLE;
        else                state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (CLOSE_REQ)
                    state_nx = S_CLOSE;
                else if (MAIN_OPEN_ACK && !TX_FULL && win_vld)
                    state_nx = S_XFER;
            end
            S_XFER: begin
                if (!MAIN_OPEN_ACK)
                    state_nx = S_FLUSH;
                else if (pkt_end)
                    state_nx = CLOSE_REQ ? S_CLOSE : S_IDLE;
            end
            S_FLUSH: begin
                if (pkt_end)
                    state_nx = CLOSE_REQ ? S_CLOSE : S_IDLE;
            end
            S_CLOSE: begin
                if (!CLOSE_REQ)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_nx       = ptr;
        grant_nx     = GRANT;
        tx_wr_nx     = 1'b0;
        tx_data_nx   = TX_DATA;
        close_ack_nx = (state_nx == S_CLOSE);
        pkt_nx       = PKT_CNT;
        drop_nx      = DROP_CNT;
        case (state)
            S_IDLE: begin
                if (state_nx == S_XFER) begin
                    ptr_nx   = win;
                    grant_nx = NUM_SRC'(1) << win;
                end
            end
            S_XFER: begin
                if (!MAIN_OPEN_ACK) begin
                    if (DROP_CNT != 8'hFF)
                        drop_nx = DROP_CNT + 8'd1;
                end else if (xfer_go) begin
                    tx_wr_nx   = 1'b1;
                    tx_data_nx = own_data;
                    if (own_last) begin
                        pkt_nx   = PKT_CNT + 16'd1;
                        grant_nx = '0;
                    end
                end
            end
            S_FLUSH: begin
                if (pkt_end)
                    grant_nx = '0;
            end
            default: ;
        endcase
    end

    // ptr resets to the last index so source 0 wins the first arbitration
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ptr       <= PTR_W'(NUM_SRC - 1);
            GRANT     <= '0;
            TX_WR     <= 1'b0;
            TX_DATA   <= 8'h00;
            CLOSE_ACK <= 1'b0;
            PKT_CNT   <= 16'h0000;
            DROP_CNT  <= 8'h00;
        end else if (SITCP_RST) begin
            ptr       <= PTR_W'(NUM_SRC - 1);
            GRANT     <= '0;
            TX_WR     <= 1'b0;
            TX_DATA   <= 8'h00;
            CLOSE_ACK <= 1'b0;
            PKT_CNT   <= 16'h0000;
            DROP_CNT  <= 8'h00;
        end else begin
            ptr       <= ptr_nx;
            GRANT     <= grant_nx;
            TX_WR     <= tx_wr_nx;
            TX_DATA   <= tx_data_nx;
            CLOSE_ACK <= close_ack_nx;
            PKT_CNT   <= pkt_nx;
            DROP_CNT  <= drop_nx;
        end
    end

endmodule

// File: tb/tb_sitcp_tx_scheduler.sv
// Directed bench for sitcp_tx_scheduler: FWFT source queues, write log, immediate-assertion checks.
module tb_sitcp_tx_scheduler;

    localparam int unsigned NUM_SRC = 4;

    logic                 CLK = 1'b0;
    logic                 RSTn;
    logic                 SITCP_RST;
    logic                 MAIN_OPEN_ACK;
    logic                 TX_FULL;
    logic                 CLOSE_REQ;
    logic                 CLOSE_ACK;
    logic                 TX_WR;
    logic [7:0]           TX_DATA;
    logic [NUM_SRC-1:0]   SRC_VALID;
    logic [8*NUM_SRC-1:0] SRC_DATA;
    logic [NUM_SRC-1:0]   SRC_LAST;
    logic [NUM_SRC-1:0]   SRC_RD;
    logic [NUM_SRC-1:0]   GRANT;
    logic                 BUSY;
    logic [15:0]          PKT_CNT;
    logic [7:0]           DROP_CNT;

    sitcp_tx_scheduler #(.NUM_SRC(NUM_SRC)) dut (
        .CLK(CLK), .RSTn(RSTn), .SITCP_RST(SITCP_RST),
        .MAIN_OPEN_ACK(MAIN_OPEN_ACK), .TX_FULL(TX_FULL),
        .CLOSE_REQ(CLOSE_REQ), .CLOSE_ACK(CLOSE_ACK),
        .TX_WR(TX_WR), .TX_DATA(TX_DATA),
        .SRC_VALID(SRC_VALID), .SRC_DATA(SRC_DATA), .SRC_LAST(SRC_LAST),
        .SRC_RD(SRC_RD), .GRANT(GRANT), .BUSY(BUSY),
        .PKT_CNT(PKT_CNT), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    logic [7:0]         mem   [NUM_SRC][32];
    logic               lastm [NUM_SRC][32];
    int                 head  [NUM_SRC];
    int                 tail  [NUM_SRC];
    logic [7:0]         wlog  [64];
    int                 nw;
    logic [NUM_SRC-1:0] last_rd;
    int                 errors = 0;
    int                 checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic update_src();
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (head[i] < tail[i]) begin
                SRC_VALID[i]       = 1'b1;
                SRC_DATA[8*i +: 8] = mem[i][head[i]];
                SRC_LAST[i]        = lastm[i][head[i]];
            end else begin
                SRC_VALID[i]       = 1'b0;
                SRC_DATA[8*i +: 8] = 8'h00;
                SRC_LAST[i]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        mem[i][tail[i]]   = d;
        lastm[i][tail[i]] = l;
        tail[i]++;
        update_src();
    endtask

    // One clock: sample pop strobes, advance queues, log writes, present next heads
    task automatic tick();
        #1;
        last_rd = SRC_RD;
        @(posedge CLK);
        #1;
        for (int i = 0; i < int'(NUM_SRC); i++)
            if (last_rd[i]) head[i]++;
        if (TX_WR) begin
            wlog[nw] = TX_DATA;
            nw++;
        end
        update_src();
    endtask

    initial begin
        int bad, bad2, cnt;
        int src, r, b;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        nw = 0;
        last_rd = '0;
        RSTn = 1'b1;
        SITCP_RST = 1'b0;
        MAIN_OPEN_ACK = 1'b0;
        TX_FULL = 1'b0;
        CLOSE_REQ = 1'b0;
        update_src();
        #2 RSTn = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        chk("rst_tx_wr", 32'(TX_WR), 0);
        chk("rst_grant", 32'(GRANT), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_close_ack", 32'(CLOSE_ACK), 0);
        RSTn = 1'b1;

        // 1: three-byte packet from src0
        MAIN_OPEN_ACK = 1'b1;
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
        tick();
        chk("t1_grant", 32'(GRANT), 32'h1);
        chk("t1_nowr_arb", 32'(TX_WR), 0);
        #1 chk("t1_rd", 32'(SRC_RD), 32'h1);
        tick();
        chk("t1_wr0", 32'(TX_WR), 1);
        chk("t1_d0", 32'(TX_DATA), 32'h11);
        tick();
        chk("t1_d1", 32'(TX_DATA), 32'h22);
        tick();
        chk("t1_wr2", 32'(TX_WR), 1);
        chk("t1_d2", 32'(TX_DATA), 32'h33);
        chk("t1_pkt", 32'(PKT_CNT), 1);
        chk("t1_grant_clr", 32'(GRANT), 0);
        tick();
        chk("t1_wr_end", 32'(TX_WR), 0);
        chk("t1_data_hold", 32'(TX_DATA), 32'h33);

        // 2: all sources hold two 2-byte packets; rotation starts after src0
        for (int i = 0; i < 4; i++)
            for (int p = 0; p < 2; p++)
                for (int k = 0; k < 2; k++)
                    push(i, 8'(32'h40 + 32'(i) * 16 + 32'(p) * 2 + 32'(k)), k == 1);
        nw = 0;
        bad = 0;
        for (int c = 0; c < 100 && nw < 16; c++) begin
            tick();
            if ((GRANT & (GRANT - 1'b1)) != '0) bad++;
        end
        chk("t2_nbytes", 32'(nw), 16);
        chk("t2_onehot", 32'(bad), 0);
        for (int k = 0; k < 16; k++) begin
            r   = k / 8;
            src = ((k % 8) / 2 + 1) % 4;
            b   = k % 2;
            chk($sformatf("t2_byte%0d", k), 32'(wlog[k]), 32'h40 + 32'(src) * 16 + 32'(r) * 2 + 32'(b));
        end
        chk("t2_pkt", 32'(PKT_CNT), 9);

        // 3: TX_FULL for five cycles mid-packet
        for (int k = 1; k <= 5; k++) push(2, 8'(8'hA0 + k), k == 5);
        nw = 0;
        tick();
        chk("t3_grant", 32'(GRANT), 32'h4);
        tick(); tick();
        TX_FULL = 1'b1;
        bad = 0; bad2 = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (last_rd != '0) bad++;
            if (TX_WR) bad2++;
        end
        TX_FULL = 1'b0;
        for (int c = 0; c < 20 && BUSY; c++) tick();
        chk("t3_rd_stall", 32'(bad), 0);
        chk("t3_wr_stall", 32'(bad2), 0);
        chk("t3_nbytes", 32'(nw), 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("t3_byte%0d", k), 32'(wlog[k]), 32'hA1 + 32'(k));
        chk("t3_pkt", 32'(PKT_CNT), 10);

        // 4: disconnect after two of six bytes of src1
        for (int k = 1; k <= 6; k++) push(1, 8'(8'hB0 + k), k == 6);
        nw = 0;
        tick();
        chk("t4_grant", 32'(GRANT), 32'h2);
        tick(); tick();
        MAIN_OPEN_ACK = 1'b0;
        tick();
        chk("t4_drop_nord", 32'(last_rd), 0);
        chk("t4_drop_cnt", 32'(DROP_CNT), 1);
        chk("t4_busy_flush", 32'(BUSY), 1);
        cnt = 0;
        for (int c = 0; c < 20 && BUSY; c++) begin
            tick();
            if (last_rd != '0) cnt++;
        end
        chk("t4_flush_pops", 32'(cnt), 4);
        chk("t4_nbytes", 32'(nw), 2);
        chk("t4_b0", 32'(wlog[0]), 32'hB1);
        chk("t4_b1", 32'(wlog[1]), 32'hB2);
        chk("t4_src_empty", 32'(tail[1] - head[1]), 0);
        chk("t4_pkt", 32'(PKT_CNT), 10);
        chk("t4_grant_clr", 32'(GRANT), 0);
        MAIN_OPEN_ACK = 1'b1;

        // 5: close requested during byte 1 of a 4-byte packet
        for (int k = 1; k <= 4; k++) push(3, 8'(8'hC0 + k), k == 4);
        nw = 0;
        tick();
        chk("t5_grant", 32'(GRANT), 32'h8);
        CLOSE_REQ = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (CLOSE_ACK) bad++;
        end
        tick();
        chk("t5_no_early_ack", 32'(bad), 0);
        chk("t5_ack", 32'(CLOSE_ACK), 1);
        chk("t5_nbytes", 32'(nw), 4);
        chk("t5_last", 32'(wlog[3]), 32'hC4);
        chk("t5_pkt", 32'(PKT_CNT), 11);
        push(0, 8'hD1, 1'b1);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (GRANT != '0 || last_rd != '0 || !CLOSE_ACK) bad++;
        end
        chk("t5_close_hold", 32'(bad), 0);
        CLOSE_REQ = 1'b0;
        tick();
        chk("t5_ack_drop", 32'(CLOSE_ACK), 0);
        chk("t5_idle", 32'(BUSY), 0);
        tick();
        chk("t5_single_grant", 32'(GRANT), 32'h1);
        tick();
        chk("t5_single_wr", 32'(TX_WR), 1);
        chk("t5_single_data", 32'(TX_DATA), 32'hD1);
        chk("t5_single_pkt", 32'(PKT_CNT), 12);
        chk("t5_single_clr", 32'(GRANT), 0);

        // 6: async reset mid-transfer, then synchronous SITCP_RST
        for (int k = 1; k <= 3; k++) push(0, 8'(8'hE0 + k), k == 3);
        for (int k = 1; k <= 3; k++) push(1, 8'(8'hF0 + k), k == 3);
        tick();
        chk("t6_grant", 32'(GRANT), 32'h2);
        tick();
        chk("t6_wr_pre", 32'(TX_DATA), 32'hF1);
        #2 RSTn = 1'b0;
        #1;
        chk("t6_arst_wr", 32'(TX_WR), 0);
        chk("t6_arst_data", 32'(TX_DATA), 0);
        chk("t6_arst_grant", 32'(GRANT), 0);
        chk("t6_arst_busy", 32'(BUSY), 0);
        chk("t6_arst_rd", 32'(SRC_RD), 0);
        chk("t6_arst_pkt", 32'(PKT_CNT), 0);
        chk("t6_arst_drop", 32'(DROP_CNT), 0);
        #2 RSTn = 1'b1;
        tick();
        chk("t6_first_src0", 32'(GRANT), 32'h1);
        tick();
        chk("t6_e1", 32'(TX_DATA), 32'hE1);
        SITCP_RST = 1'b1;
        #1 chk("t6_srst_nord", 32'(SRC_RD), 0);
        tick();
        SITCP_RST = 1'b0;
        chk("t6_srst_wr", 32'(TX_WR), 0);
        chk("t6_srst_data", 32'(TX_DATA), 0);
        chk("t6_srst_grant", 32'(GRANT), 0);
        chk("t6_srst_busy", 32'(BUSY), 0);
        chk("t6_srst_ack", 32'(CLOSE_ACK), 0);
        tick();
        chk("t6_srst_src0", 32'(GRANT), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
